// File: rtl/pulse_sequencer.sv
// pulse_sequencer: round-robin front end for a shared 16-bit rotating pulse
// generator. Captures one requester's pattern/count, loads the generator, gates
// its output for 16 x count cycles, then clears it and reports completion.
module pulse_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [15:0]      pattern_a,
  input  logic [15:0]      pattern_b,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  output logic             ack_a,
  output logic             ack_b,
  input  logic             abort,
  input  logic             gen_Q_out,
  output logic [15:0]      gen_Q_in,
  output logic             gen_load,
  output logic             pulse_out,
  output logic             busy,
  output logic             grant_b,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           state;
  logic             last_b;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] rep_r;
  logic [3:0]       phase_r;
  logic             win_b;

  // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
  function automatic logic pick_b(input logic ra, input logic rb, input logic last);
    return rb & (~ra | ~last);
  endfunction

  assign win_b = pick_b(req_a, req_b, last_b);

  // Only RUN lets the generator's stream through.
  assign pulse_out = gen_Q_out & (state == S_RUN);

  // Sequencer FSM; every output is registered together with the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      last_b   <= 1'b1;
      cnt_r    <= '0;
      rep_r    <= '0;
      phase_r  <= '0;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      busy     <= 1'b0;
      grant_b  <= 1'b0;
      gen_load <= 1'b1;
      gen_Q_in <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          aborted  <= 1'b0;
          gen_load <= 1'b1;
          gen_Q_in <= '0;
          ack_a    <= 1'b0;
          ack_b    <= 1'b0;
          busy     <= 1'b0;
          if (req_a || req_b) begin
            state    <= S_LOAD;
            grant_b  <= win_b;
            last_b   <= win_b;
            cnt_r    <= win_b ? count_b : count_a;
            gen_Q_in <= win_b ? pattern_b : pattern_a;
            ack_a    <= ~win_b;
            ack_b    <= win_b;
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          if (abort || (cnt_r == '0)) begin
            state    <= S_DONE;
            done     <= 1'b1;
            aborted  <= abort;
            gen_load <= 1'b1;
            gen_Q_in <= '0;
          end else begin
            state    <= S_RUN;
            gen_load <= 1'b0;
            phase_r  <= '0;
            rep_r    <= cnt_r;
          end
        end
        S_RUN: begin
          phase_r <= phase_r + 4'd1;
          if (abort || ((phase_r == 4'd15) && (rep_r == CNT_W'(1)))) begin
            state    <= S_DONE;
            done     <= 1'b1;
            aborted  <= abort;
            gen_load <= 1'b1;
            gen_Q_in <= '0;
          end else if (phase_r == 4'd15) begin
            rep_r <= rep_r - CNT_W'(1);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done    <= 1'b0;
          aborted <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer with a behavioural rotating pulse generator.
module tb_pulse_sequencer;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             req_a, req_b;
  logic [15:0]      pattern_a, pattern_b;
  logic [CNT_W-1:0] count_a, count_b;
  logic             ack_a, ack_b;
  logic             abort;
  logic             gen_Q_out;
  logic [15:0]      gen_Q_in;
  logic             gen_load;
  logic             pulse_out, busy, grant_b, done, aborted;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  bit grant_q[$];

  pulse_sequencer #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST),
    .req_a(req_a), .req_b(req_b),
    .pattern_a(pattern_a), .pattern_b(pattern_b),
    .count_a(count_a), .count_b(count_b),
    .ack_a(ack_a), .ack_b(ack_b),
    .abort(abort),
    .gen_Q_out(gen_Q_out), .gen_Q_in(gen_Q_in), .gen_load(gen_load),
    .pulse_out(pulse_out), .busy(busy), .grant_b(grant_b),
    .done(done), .aborted(aborted)
  );

  always #5 CLK = ~CLK;

  // Generator model: load on gen_load, otherwise rotate left; MSB is the output.
  logic [15:0] gen_r = '0;
  always_ff @(posedge CLK) begin
    if (gen_load) gen_r <= gen_Q_in;
    else          gen_r <= {gen_r[14:0], gen_r[15]};
  end
  assign gen_Q_out = gen_r[15];

  task automatic push_pattern(input logic [15:0] pat, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 15; i >= 0; i--) exp_q.push_back(pat[i]);
  endtask

  task automatic test_reset;
    bit seen;
    RST = 1'b1; req_a = 0; req_b = 0; abort = 0;
    pattern_a = '0; pattern_b = '0; count_a = '0; count_b = '0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({ack_a, ack_b, done, aborted, busy, grant_b, pulse_out} !== 7'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b, want 0000000", {ack_a, ack_b, done, aborted, busy, grant_b, pulse_out});
    end
    n_checks++;
    if (gen_load !== 1'b1 || gen_Q_in !== 16'h0) begin
      n_fail++; $display("FAIL reset_gen: got load=%b q_in=%h, want load=1 q_in=0000", gen_load, gen_Q_in);
    end
    // start a job, then reset it mid-RUN
    RST = 1'b0; pattern_a = 16'hFFFF; count_a = 8'd2; req_a = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ack_a !== 1'b1) begin n_fail++; $display("FAIL reset_job_ack: got %b, want 1", ack_a); end
    req_a = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if (pulse_out !== 1'b1) begin n_fail++; $display("FAIL reset_pre_run: got %b, want 1", pulse_out); end
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (pulse_out !== 1'b0 || busy !== 1'b0 || gen_load !== 1'b1 || gen_Q_in !== 16'h0) begin
      n_fail++; $display("FAIL reset_mid_run: got pulse=%b busy=%b load=%b q_in=%h, want 0 0 1 0000", pulse_out, busy, gen_load, gen_Q_in);
    end
    @(negedge CLK);
    RST = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge CLK);
      seen |= busy | ack_a | ack_b | pulse_out | done;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_stays_idle: got activity=%b, want 0", seen); end
  endtask

  task automatic test_single_job;
    bit e;
    pattern_a = 16'hA001; count_a = 8'd2; req_a = 1'b1;
    push_pattern(16'hA001, 2);
    @(negedge CLK);
    n_checks++;
    if (ack_a !== 1'b1 || ack_b !== 1'b0 || grant_b !== 1'b0) begin
      n_fail++; $display("FAIL single_ack: got ack_a=%b ack_b=%b grant_b=%b, want 1 0 0", ack_a, ack_b, grant_b);
    end
    req_a = 1'b0;
    while (exp_q.size() > 0) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      n_checks++;
      if (pulse_out !== e || done !== 1'b0) begin
        n_fail++; $display("FAIL single_pulse: got pulse=%b done=%b, want pulse=%b done=0", pulse_out, done, e);
      end
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || pulse_out !== 1'b0 || gen_load !== 1'b1 || gen_Q_in !== 16'h0) begin
      n_fail++; $display("FAIL single_done: got done=%b aborted=%b pulse=%b load=%b q_in=%h, want 1 0 0 1 0000", done, aborted, pulse_out, gen_load, gen_Q_in);
    end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_idle: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_tie_arbitration;
    int acks, last_c;
    bit e, got_done;
    RST = 1'b1;
    pattern_a = 16'h8001; pattern_b = 16'h0003; count_a = 8'd1; count_b = 8'd1;
    req_a = 1'b1; req_b = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    grant_q.push_back(1'b0); grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    acks = 0; last_c = 0;
    for (int c = 0; c < 100 && acks < 3; c++) begin
      @(negedge CLK);
      if (ack_a || ack_b) begin
        e = grant_q.pop_front();
        n_checks++;
        if (grant_b !== e || ack_a !== ~e || ack_b !== e) begin
          n_fail++; $display("FAIL tie_grant%0d: got grant_b=%b ack_a=%b ack_b=%b, want grant_b=%b", acks, grant_b, ack_a, ack_b, e);
        end
        if (acks > 0) begin
          n_checks++;
          if (c - last_c != 19) begin
            n_fail++; $display("FAIL tie_spacing%0d: got %0d cycles, want 19", acks, c - last_c);
          end
        end
        last_c = c;
        acks++;
        if (acks == 3) begin req_a = 1'b0; req_b = 1'b0; end
      end
    end
    n_checks++;
    if (acks != 3) begin n_fail++; $display("FAIL tie_ack_count: got %0d, want 3", acks); end
    req_a = 1'b0; req_b = 1'b0;
    got_done = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      @(negedge CLK);
      got_done = done;
    end
    n_checks++;
    if (!got_done) begin n_fail++; $display("FAIL tie_final_done: got 0, want 1"); end
    @(negedge CLK);
  endtask

  task automatic test_count_zero;
    bit saw;
    pattern_b = 16'hFFFF; count_b = 8'd0; req_b = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (ack_b !== 1'b1 || ack_a !== 1'b0 || grant_b !== 1'b1) begin
      n_fail++; $display("FAIL zero_ack: got ack_b=%b ack_a=%b grant_b=%b, want 1 0 1", ack_b, ack_a, grant_b);
    end
    req_b = 1'b0;
    saw = pulse_out;
    @(negedge CLK);
    saw |= pulse_out;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got done=%b aborted=%b, want 1 0", done, aborted);
    end
    repeat (3) begin
      @(negedge CLK);
      saw |= pulse_out;
    end
    n_checks++;
    if (saw !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_no_pulse: got pulse_seen=%b busy=%b, want 0 0", saw, busy);
    end
  endtask

  task automatic run_abort(input string name, input int count, input int abort_at);
    int ones;
    bit e;
    pattern_a = 16'hFFFF; count_a = count[CNT_W-1:0]; req_a = 1'b1;
    for (int i = 0; i < abort_at; i++) exp_q.push_back(1'b1);
    @(negedge CLK);
    n_checks++;
    if (ack_a !== 1'b1) begin n_fail++; $display("FAIL %s_ack: got %b, want 1", name, ack_a); end
    req_a = 1'b0;
    ones = 0;
    for (int j = 1; j <= abort_at; j++) begin
      @(negedge CLK);
      e = exp_q.pop_front();
      ones += int'(pulse_out);
      n_checks++;
      if (pulse_out !== e) begin n_fail++; $display("FAIL %s_pulse%0d: got %b, want %b", name, j, pulse_out, e); end
      if (j == abort_at) abort = 1'b1;
    end
    @(negedge CLK);
    abort = 1'b0;
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || pulse_out !== 1'b0 || gen_load !== 1'b1 || gen_Q_in !== 16'h0) begin
      n_fail++; $display("FAIL %s_done: got done=%b aborted=%b pulse=%b load=%b q_in=%h, want 1 1 0 1 0000", name, done, aborted, pulse_out, gen_load, gen_Q_in);
    end
    n_checks++;
    if (ones != abort_at) begin n_fail++; $display("FAIL %s_ones: got %0d, want %0d", name, ones, abort_at); end
    @(negedge CLK);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pulse_out !== 1'b0) begin
      n_fail++; $display("FAIL %s_after: got done=%b busy=%b pulse=%b, want 0 0 0", name, done, busy, pulse_out);
    end
  endtask

  task automatic test_abort;
    run_abort("abort_run", 3, 5);
  endtask

  task automatic test_abort_last_phase;
    run_abort("abort_last", 1, 16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_job();
    test_tie_arbitration();
    test_count_zero();
    test_abort();
    test_abort_last_phase();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
# pulse_sequencer

Controller that shares the 16-bit rotating pulse generator between two requesters. Each requester supplies a 16-bit pattern and a repeat count. The sequencer arbitrates round-robin, loads the winning pattern into the generator, and gates the generator output for exactly 16 × count cycles. It then clears the generator and reports completion. It sits between the requesting logic and a pulse_generator instance, driving that instance's `Q_in` and `load` and consuming its `Q_out`.

## Interface
- `CNT_W`, default 8: width of the repeat-count inputs and of the internal repeat counter.
- `CLK`  in  1  system clock; all state changes on the rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `req_a` / `req_b`  in  1  each is a level request for one job.
- `pattern_a` / `pattern_b`  in  16  pattern to emit. Bit 15 is emitted first.
- `count_a` / `count_b`  in  CNT_W  number of 16-cycle periods to emit.
- `ack_a` / `ack_b`  out  1  one-cycle pulse: the job is accepted and its inputs are captured.
- `abort`  in  1  terminates the active job.
- `gen_Q_out`  in  1  from the generator's `Q_out`.
- `gen_Q_in`  out  16  to the generator's `Q_in`.
- `gen_load`  out  1  to the generator's `load`.
- `pulse_out`  out  1  gated pulse stream.
- `busy`  out  1  high in LOAD, RUN and DONE.
- `grant_b`  out  1  0 means A owns the active or last job; 1 means B.
- `done`  out  1  one-cycle completion pulse.
- `aborted`  out  1  valid with `done`; 1 if the job ended by abort.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. All outputs decode from registered state. `pulse_out` is the only combinational output: `pulse_out = gen_Q_out & (state == RUN)`.
- **IDLE:**
  - Outputs: `gen_load = 1`, `gen_Q_in = 0`. This holds the generator cleared.
  - If any `req` is high at the edge:
    - Pick a winner.
    - Capture its pattern and count into internal registers.
    - Set `grant_b` to the winner and update the last-grant pointer.
    - Go to LOAD.
- **Arbitration:**
  - A single requester always wins.
  - If both request, the requester not granted last wins.
  - After reset the pointer equals B, so A wins the first tie.
- **LOAD** (exactly one cycle):
  - Outputs: `gen_load = 1`, `gen_Q_in` = captured pattern, `ack` of the winner = 1.
  - If captured count = 0, go to DONE. Nothing is emitted.
  - Otherwise go to RUN. Clear the 4-bit phase counter and load the repeat counter with the count.
- **RUN:**
  - `gen_load = 0`, so the generator rotates.
  - The phase counter increments every cycle, wrapping 15 → 0.
  - At phase 15: if repeat = 1, go to DONE; otherwise decrement repeat.
  - Emitted sequence: `pattern[15], pattern[14], …, pattern[0]`, repeated count times. That is exactly 16 × count cycles of `pulse_out`.
- **DONE** (exactly one cycle):
  - Outputs: `done = 1`, `aborted` as latched, `gen_load = 1`, `gen_Q_in = 0` (clears the generator), `pulse_out = 0`.
  - Go to IDLE.
  - Arbitration happens only in IDLE.
- **abort:**
  - Sampled in LOAD or RUN. Goes to DONE on the next edge with `aborted = 1`.
  - Ignored in IDLE and DONE.
  - An abort in LOAD still produces the `ack` pulse.
- **Handshake:**
  - The requester holds `req`, pattern and count stable until it sees `ack`.
  - One `ack` consumes one job.
  - A `req` still high when the FSM returns to IDLE is a new job.
- **Width rules:**
  - The repeat counter is CNT_W bits; the maximum job is 16 × (2^CNT_W − 1) cycles.
  - Count 0 is legal and produces no pulses.

## Timing
- **Reset:** `RST` high at an edge forces the following values, overriding everything including abort:
  - state IDLE, last-grant pointer = B, internal registers 0
  - `ack_a = ack_b = 0`, `done = 0`, `aborted = 0`, `busy = 0`, `grant_b = 0`, `pulse_out = 0`
  - `gen_load = 1`, `gen_Q_in = 0`
- **Reset mid-RUN:** `pulse_out` is 0 from the edge onward. The generator is cleared at the next edge.
- **Job schedule,** with `req` first sampled at edge k in IDLE:
  - cycle k+1: LOAD with `ack`
  - cycles k+2 … k+1+16N: RUN. The first RUN cycle shows `pattern[15]`.
  - cycle k+2+16N: DONE
  - cycle k+3+16N: IDLE
  - cycle k+4+16N: earliest next LOAD
- **Count 0:** LOAD at k+1, DONE at k+2, no RUN cycles.
- **Abort during RUN:** an abort sampled at edge m puts DONE in cycle m+1, with `pulse_out = 0` from cycle m+1.
- **Abort on the final phase:** abort together with phase 15 / repeat 1 gives DONE with `aborted = 1`.
- **Requests during a job:** requests arriving during LOAD, RUN or DONE wait. They are evaluated in IDLE with the updated pointer.

## Test plan
- **Reset:** assert `RST` for 2 cycles during RUN -> next cycle `pulse_out = 0`, `busy = 0`, `gen_load = 1`, `gen_Q_in = 0`; after release with no `req`, the FSM stays IDLE.
- **Single job:** `req_a` with `pattern_a = 16'hA001`, `count_a = 2` -> `ack_a` one cycle after sampling; 32 RUN cycles with `pulse_out` = 1,0,1,0, then 11 zeros, then 1, repeated twice; `done = 1`, `aborted = 0` in the next cycle.
- **Tie arbitration:** `req_a` and `req_b` both held from reset, count 1 each -> A granted first, then B, then A; `grant_b` = 0, 1, 0; exactly one ack per job.
- **Count zero:** `req_b`, `count_b = 0`, `pattern_b = 16'hFFFF` -> `ack_b`, then `done` two cycles after sampling; `pulse_out` never 1.
- **Abort:** `pattern_a = 16'hFFFF`, `count_a = 3`, `abort` pulsed on the 5th RUN cycle -> exactly 5 ones on `pulse_out`; `done = 1`, `aborted = 1` next cycle; `gen_Q_in = 0` with `gen_load = 1` in DONE.
- **Abort on last phase:** `abort` coincident with the last RUN cycle of a count-1 job -> `done` with `aborted = 1`, 16 pulses emitted.
